// File: rtl/lc3b_types.sv
// lc3b_types: shared types for the LC-3b pipeline.
//   lc3b_word      - 16-bit data/address word
//   lc3b_if_state  - fetch-stage controller states
//   lc3b_if_id     - IF/ID pipeline latch contents
//   force_even()   - clears bit 0 so an address is word aligned
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } lc3b_if_state;

  typedef struct packed {
    lc3b_word instr;
    lc3b_word pc;
    logic     valid;
  } lc3b_if_id;

  localparam lc3b_word PC_STEP = 16'd2;

  function automatic lc3b_word force_even(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: single-outstanding-request instruction-memory bus.
//   read    - read request, held until resp
//   address - word-aligned read address, stable while read is pending
//   rdata   - returned instruction, valid while resp = 1
//   resp    - one-cycle read-complete pulse
// Modports: master = fetch stage, slave = instruction memory.
interface if_stage_if;
  import lc3b_types::*;

  logic     read;
  lc3b_word address;
  lc3b_word rdata;
  logic     resp;

  modport master (output read, address, input  rdata, resp);
  modport slave  (input  read, address, output rdata, resp);

endinterface

// File: rtl/if_stage_reg.sv
// if_stage_reg: generic load-enabled register with synchronous reset.
//   clk   - clock
//   reset - synchronous active-high reset, loads RESET_VAL
//   load  - capture d on the next rising edge
//   d / q - data in / registered data out
module if_stage_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset)     q <= RESET_VAL;
    else if (load) q <= d;
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: LC-3b instruction-fetch stage.
//   clk, reset        - clock, synchronous active-high reset
//   stall             - downstream cannot accept; IF/ID latch holds
//   redirect          - taken branch/jump/trap; flush and refetch
//   redirect_pc       - redirect target (bit 0 forced to 0)
//   imem              - instruction-memory master port
//   instruction_out   - IF/ID instruction
//   pc_out            - IF/ID PC+2 of that instruction
//   valid_out         - IF/ID holds a real instruction, not a bubble
module if_stage
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  lc3b_word          redirect_pc,
  if_stage_if.master        imem,
  output lc3b_word          instruction_out,
  output lc3b_word          pc_out,
  output logic              valid_out
);

  lc3b_if_state state, state_next;

  lc3b_word  pc, pc_next, pc_plus2, target;
  lc3b_word  hold_instr, pend_pc;
  lc3b_word  deliver_instr;
  logic      pc_load, hold_load, pend_load, deliver;
  lc3b_if_id if_id_q, if_id_d;
  logic      if_id_load;

  assign pc_plus2 = pc + PC_STEP;  // 16-bit wrap is intended
  assign target   = force_even(redirect_pc);

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    imem.read     = 1'b0;
    pc_load       = 1'b0;
    pc_next       = pc_plus2;
    hold_load     = 1'b0;
    pend_load     = 1'b0;
    deliver       = 1'b0;
    deliver_instr = imem.rdata;

    case (state)
      FETCH: begin
        imem.read = 1'b1;
        if (imem.resp) begin
          if (redirect) begin
            pc_load = 1'b1;
            pc_next = target;
          end else if (!stall) begin
            deliver = 1'b1;
            pc_load = 1'b1;
          end else begin
            hold_load  = 1'b1;
            state_next = HOLD;
          end
        end else if (redirect) begin
          // The request is already on the bus; wait it out, then refetch.
          pend_load  = 1'b1;
          state_next = DISCARD;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_load    = 1'b1;
          pc_next    = target;
          state_next = FETCH;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr;
          pc_load       = 1'b1;
          state_next    = FETCH;
        end
      end

      DISCARD: begin
        imem.read = 1'b1;
        pend_load = redirect;  // latest redirect wins
        if (imem.resp) begin
          pc_load    = 1'b1;
          pc_next    = redirect ? target : pend_pc;
          state_next = FETCH;
        end
      end

      default: state_next = FETCH;
    endcase

    if (reset) imem.read = 1'b0;
  end

  assign imem.address = pc;

  // IF/ID latch: redirect flushes even under stall; stall otherwise freezes
  // everything; an idle cycle inserts a bubble but keeps instr/pc.
  assign if_id_load = redirect | ~stall;

  always_comb begin
    if_id_d       = if_id_q;
    if_id_d.valid = deliver;
    if (deliver) begin
      if_id_d.instr = deliver_instr;
      if_id_d.pc    = pc_plus2;
    end
  end

  if_stage_reg #(.WIDTH(16), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .load(pc_load), .d(pc_next), .q(pc)
  );

  if_stage_reg #(.WIDTH(16)) u_hold_instr (
    .clk(clk), .reset(reset), .load(hold_load), .d(imem.rdata), .q(hold_instr)
  );

  if_stage_reg #(.WIDTH(16)) u_pend_pc (
    .clk(clk), .reset(reset), .load(pend_load), .d(target), .q(pend_pc)
  );

  if_stage_reg #(.WIDTH($bits(lc3b_if_id))) u_if_id (
    .clk(clk), .reset(reset), .load(if_id_load), .d(if_id_d), .q(if_id_q)
  );

  assign instruction_out = if_id_q.instr;
  assign pc_out          = if_id_q.pc;
  assign valid_out       = if_id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed, self-checking bench for if_stage. Expected IF/ID
// entries are queued when a delivering response is driven and popped after
// the edge that should latch them.
module tb_if_stage;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     stall;
  logic     redirect;
  lc3b_word redirect_pc;
  lc3b_word instruction_out;
  lc3b_word pc_out;
  logic     valid_out;

  if_stage_if bus ();

  if_stage #(.RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem            (bus),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .valid_out       (valid_out)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_errors = 0;
  lc3b_if_id sb[$];
  lc3b_if_id last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_latch(input logic exp_v);
    check("valid_out", {31'd0, valid_out}, {31'd0, exp_v});
    if (sb.size() != 0) last = sb.pop_front();
    check("instruction_out", {16'd0, instruction_out}, {16'd0, last.instr});
    check("pc_out", {16'd0, pc_out}, {16'd0, last.pc});
  endtask

  task automatic do_reset(input logic rsp);
    @(negedge clk);
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    bus.resp    = rsp;
    bus.rdata   = 16'hFACE;
    #1;
    check("imem_read_in_reset", {31'd0, bus.read}, 32'd0);
    @(posedge clk);
    #1;
    sb.delete();
    last = '0;
    compare_latch(1'b0);
  endtask

  // One cycle: drive inputs at the falling edge, check the request side,
  // then check the IF/ID latch after the rising edge.
  task automatic step(input logic rsp, input lc3b_word rd, input logic st,
                      input logic rdr, input lc3b_word rpc,
                      input logic exp_rd, input lc3b_word exp_addr,
                      input logic exp_v, input logic dlv,
                      input lc3b_word dlv_instr, input lc3b_word dlv_pc);
    lc3b_if_id e;
    @(negedge clk);
    reset       = 1'b0;
    bus.resp    = rsp;
    bus.rdata   = rd;
    stall       = st;
    redirect    = rdr;
    redirect_pc = rpc;
    #1;
    check("imem_read", {31'd0, bus.read}, {31'd0, exp_rd});
    if (exp_rd) check("imem_address", {16'd0, bus.address}, {16'd0, exp_addr});
    if (dlv) begin
      e.instr = dlv_instr;
      e.pc    = dlv_pc;
      e.valid = 1'b1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    compare_latch(exp_v);
  endtask

  initial begin
    bus.resp  = 1'b0;
    bus.rdata = 16'h0000;
    last      = '0;

    // Back-to-back zero-wait fetches.
    do_reset(1'b0);
    step(1, 16'h1234, 0, 0, 16'h0, 1, 16'h0000, 1, 1, 16'h1234, 16'h0002);
    step(1, 16'h5678, 0, 0, 16'h0, 1, 16'h0002, 1, 1, 16'h5678, 16'h0004);
    step(0, 16'h0000, 0, 0, 16'h0, 1, 16'h0004, 0, 0, 16'h0, 16'h0);

    // Stall during a response: HOLD for three cycles, then release.
    do_reset(1'b0);
    step(1, 16'h1234, 0, 0, 16'h0, 1, 16'h0000, 1, 1, 16'h1234, 16'h0002);
    step(1, 16'hABCD, 1, 0, 16'h0, 1, 16'h0002, 1, 0, 16'h0, 16'h0);
    step(0, 16'h0000, 1, 0, 16'h0, 0, 16'h0000, 1, 0, 16'h0, 16'h0);
    step(0, 16'h0000, 1, 0, 16'h0, 0, 16'h0000, 1, 0, 16'h0, 16'h0);
    step(0, 16'h0000, 0, 0, 16'h0, 0, 16'h0000, 1, 1, 16'hABCD, 16'h0004);
    step(0, 16'h0000, 0, 0, 16'h0, 1, 16'h0004, 0, 0, 16'h0, 16'h0);

    // Advance to 0x0010.
    for (int a = 4; a < 16; a += 2)
      step(1, lc3b_word'(16'h1000 + a), 0, 0, 16'h0, 1, lc3b_word'(a), 1, 1,
           lc3b_word'(16'h1000 + a), lc3b_word'(a + 2));

    // Redirect while a request is pending; a second (odd) redirect wins.
    step(0, 16'h0000, 0, 1, 16'h2222, 1, 16'h0010, 0, 0, 16'h0, 16'h0);
    step(0, 16'h0000, 0, 1, 16'h3001, 1, 16'h0010, 0, 0, 16'h0, 16'h0);
    step(1, 16'hDEAD, 0, 0, 16'h0000, 1, 16'h0010, 0, 0, 16'h0, 16'h0);
    step(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3000, 0, 0, 16'h0, 16'h0);

    // Redirect coinciding with a response.
    step(1, 16'h1111, 0, 1, 16'h001E, 1, 16'h3000, 0, 0, 16'h0, 16'h0);
    step(1, 16'h2222, 0, 0, 16'h0000, 1, 16'h001E, 1, 1, 16'h2222, 16'h0020);
    step(1, 16'h3333, 0, 1, 16'h4000, 1, 16'h0020, 0, 0, 16'h0, 16'h0);

    // Redirect under stall while in HOLD.
    step(1, 16'h4444, 0, 0, 16'h0000, 1, 16'h4000, 1, 1, 16'h4444, 16'h4002);
    step(1, 16'hBEEF, 1, 0, 16'h0000, 1, 16'h4002, 1, 0, 16'h0, 16'h0);
    step(0, 16'h0000, 1, 1, 16'h5000, 0, 16'h0000, 0, 0, 16'h0, 16'h0);
    step(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h5000, 0, 0, 16'h0, 16'h0);

    // PC wrap at 0xFFFE.
    step(1, 16'h0000, 0, 1, 16'hFFFE, 1, 16'h5000, 0, 0, 16'h0, 16'h0);
    step(1, 16'h7777, 0, 0, 16'h0000, 1, 16'hFFFE, 1, 1, 16'h7777, 16'h0000);

    // Reset while in DISCARD, with a stray response during reset.
    step(1, 16'h0101, 0, 0, 16'h0000, 1, 16'h0000, 1, 1, 16'h0101, 16'h0002);
    step(0, 16'h0000, 0, 1, 16'h6000, 1, 16'h0002, 0, 0, 16'h0, 16'h0);
    do_reset(1'b1);
    step(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0, 16'h0);
    step(1, 16'h9999, 0, 0, 16'h0000, 1, 16'h0000, 1, 1, 16'h9999, 16'h0002);
    step(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 0, 0, 16'h0, 16'h0);

    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined LC-3b core, directly upstream of the decode stage.
- Owns the PC and drives a single-outstanding-request instruction-memory handshake.
- Holds the IF/ID latch: instruction, incremented PC and valid bit feeding decode.
- Honours downstream stall and branch/jump redirect (flush), including redirects that arrive while a memory request is in flight.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  decode or later stages cannot accept; hold IF/ID latch.
redirect  input  1  taken branch/jump/trap resolved downstream; flush and refetch.
redirect_pc  input  16 (lc3b_word)  target address for redirect.
imem_read  output  1  instruction-memory read request.
imem_address  output  16 (lc3b_word)  read address; word aligned, bit 0 = 0.
imem_rdata  input  16 (lc3b_word)  returned instruction, valid when imem_resp = 1.
imem_resp  input  1  one-cycle read-complete pulse.
instruction_out  output  16 (lc3b_word)  IF/ID instruction to decode.
pc_out  output  16 (lc3b_word)  IF/ID PC+2 of that instruction.
valid_out  output  1  IF/ID contents are a real instruction, not a bubble.

Behaviour:
- Reset:
  - pc = RESET_PC; state = FETCH.
  - instruction_out = 0, pc_out = 0, valid_out = 0.
  - hold buffer and pending target cleared.
  - imem_read = 0 during the reset cycle; asserted from the first cycle after reset.
  - Reset mid-request abandons it; any later imem_resp while in DISCARD is simply consumed.
- imem_address = pc in FETCH and DISCARD. It must stay stable while imem_read = 1 and no imem_resp has occurred.
- States:
  - FETCH: imem_read = 1.
    - imem_resp & redirect: drop rdata; pc <= redirect_pc; stay FETCH.
    - imem_resp & !stall: instruction_out <= imem_rdata; pc_out <= pc+2; valid_out <= 1; pc <= pc+2; stay FETCH.
    - imem_resp & stall: hold_instr <= imem_rdata; go HOLD.
    - !imem_resp & redirect: pend_pc <= redirect_pc; go DISCARD (request already issued, cannot be cancelled).
  - HOLD: imem_read = 0.
    - redirect: drop hold buffer; pc <= redirect_pc; go FETCH.
    - !stall: IF/ID <= {hold_instr, pc+2, valid = 1}; pc <= pc+2; go FETCH.
  - DISCARD: imem_read = 1 at the old address.
    - New redirect updates pend_pc; latest redirect wins.
    - On imem_resp: drop rdata; pc <= redirect ? redirect_pc : pend_pc; go FETCH.
- IF/ID latch rules, in priority order:
  1. redirect (any state) -> valid_out <= 0 next edge, even if stall = 1.
  2. stall -> all three latch outputs hold their value.
  3. No instruction delivered this cycle -> valid_out <= 0 (bubble); instruction_out and pc_out hold.
- Arithmetic: pc+2 is 16-bit modulo; 16'hFFFE + 2 = 16'h0000, no flag.
- Latency: with zero-wait memory (imem_resp the same cycle as the request), one instruction per cycle. Throughput is otherwise one per memory response.
- Redirect targets with bit 0 = 1 are forced even (bit 0 cleared).

Decomposition:
- In lc3b_types: enum lc3b_if_state {FETCH, HOLD, DISCARD}. lc3b_word is reused for all 16-bit fields.
- RESET_PC stays a module parameter.
- One sub-module: the existing generic load-enabled register, instantiated for pc, hold_instr, pend_pc and the IF/ID latch.
- The FSM and next-PC mux stay inline.

Test Plan:
- Reset, then imem_resp every cycle with rdata = 0x1234, 0x5678 -> addresses 0x0000, 0x0002, 0x0004; IF/ID shows {0x1234, pc_out 0x0002, valid 1} then {0x5678, 0x0004, 1}.
- Stall during resp with rdata = 0xABCD, held 3 cycles -> latch unchanged and imem_read = 0 in HOLD. On release, IF/ID = {0xABCD, 0x0004, 1}; next address 0x0004.
- Redirect to 0x3000 while request at 0x0010 pending, resp 2 cycles later -> address stays 0x0010 until resp, rdata discarded, next address 0x3000, valid_out = 0 throughout.
- Redirect to 0x4000 the same cycle as resp at 0x0020 -> instruction dropped, next address 0x4000, valid_out 0 next cycle.
- Redirect with stall = 1 while in HOLD -> valid_out cleared next edge, buffer dropped, fetch from target.
- PC = 0xFFFE, resp -> pc_out = 0x0000, next address 0x0000.
- Reset asserted in DISCARD -> next cycle pc = RESET_PC, valid_out = 0, a stray resp is ignored.
